// File: rtl/sram_pixel_writer.sv
// sram_pixel_writer: queues (x,y,colour) pixels and turns them into asynchronous-SRAM write cycles while the bus is granted.
// Latency: pixel accepted at edge N into an empty queue with grant high -> SETUP at N+1, WE_N low N+2..N+1+WE_CYCLES; one pixel per 2+WE_CYCLES clocks.
// Backpressure: pix_ready = ~fifo_full (and low during RESET); a full queue never accepts, even when it pops that cycle.
//
// Ports: CLOCK_50 / RESET (synchronous, active-high)
//        pix_valid, pix_ready, pix_x, pix_y, pix_color : drawing-side pixel port
//        bus_grant, bus_req                             : SRAM bus arbiter handshake
//        busy, drop_count                               : status (drop_count saturates at 16'hFFFF)
//        SRAM_ADDR, SRAM_DQ, SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N : SRAM pins
// Optional feature: define COLOR_KEY_EN to discard pixels whose colour equals KEY_COLOR.

// fifo: generic synchronous queue, first-word-fall-through read data.
// Latency: a write is visible at rd_dat one clock later; a read pops on the clock edge.
// Backpressure: full blocks writes (wr_vld ignored when full), empty blocks reads.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             full,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_wr;
    logic             do_rd;

    assign full   = (count == (PTR_W+1)'(DEPTH));
    assign empty  = (count == '0);
    assign do_wr  = wr_vld & ~full;
    assign do_rd  = rd_rdy & ~empty;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

module sram_pixel_writer #(
    parameter int          H_RES      = 640,
    parameter int          V_RES      = 400,
    parameter int          FIFO_DEPTH = 4,
    parameter int          WE_CYCLES  = 2,
    parameter logic [11:0] KEY_COLOR  = 12'h000
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [11:0] pix_x,
    input  logic [11:0] pix_y,
    input  logic [11:0] pix_color,
    input  logic        bus_grant,
    output logic        bus_req,
    output logic        busy,
    output logic [15:0] drop_count,
    output logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);
    // Address is computed at enqueue time so the queue holds exactly what the SRAM cycle needs.
    typedef struct packed {
        logic [17:0] addr;
        logic [11:0] color;
    } pix_t;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    localparam int CNT_W = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

    state_t           state;
    logic [CNT_W-1:0] strobe_cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             accept;
    logic             in_range;
    logic             keyed;
    logic             push_vld;
    logic             pop_rdy;
    pix_t             push_dat;
    pix_t             head_dat;
    logic [17:0]      addr_q;
    logic [15:0]      dq_dat;
    logic             dq_oe;
    logic             we_n;

    assign pix_ready = ~RESET & ~fifo_full;
    assign accept    = pix_valid & pix_ready;
    assign in_range  = (pix_x < 12'(H_RES)) && (pix_y < 12'(V_RES));

`ifdef COLOR_KEY_EN
    assign keyed = (pix_color == KEY_COLOR);
`else
    // Colour keying disabled: the compare is masked so KEY_COLOR has no effect.
    assign keyed = 1'b0 & (pix_color == KEY_COLOR);
`endif

    assign push_vld       = accept & in_range & ~keyed;
    // In-range pixels give y*H_RES+x < 2^18, so 18-bit arithmetic is exact.
    assign push_dat.addr  = 18'(pix_y) * 18'(H_RES) + 18'(pix_x);
    assign push_dat.color = pix_color;

    // The head is popped on the edge that enters SETUP (from IDLE or back-to-back from HOLD).
    assign pop_rdy = ((state == IDLE) || (state == HOLD)) & ~fifo_empty & bus_grant;

    fifo #(
        .WIDTH ($bits(pix_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .wr_vld   (push_vld),
        .wr_dat   (push_dat),
        .full     (fifo_full),
        .rd_rdy   (pop_rdy),
        .rd_dat   (head_dat),
        .empty    (fifo_empty)
    );

    // Write-cycle sequencer; grant is only consulted when starting a cycle, so a started cycle always completes.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state      <= IDLE;
            strobe_cnt <= '0;
            addr_q     <= '0;
            dq_dat     <= '0;
            dq_oe      <= 1'b0;
            we_n       <= 1'b1;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    we_n <= 1'b1;
                    if (pop_rdy) begin
                        state  <= SETUP;
                        addr_q <= head_dat.addr;
                        dq_dat <= {4'h0, head_dat.color};
                        dq_oe  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        dq_oe <= 1'b0;
                    end
                end
                SETUP: begin
                    state      <= STROBE;
                    we_n       <= 1'b0;
                    strobe_cnt <= CNT_W'(WE_CYCLES - 1);
                end
                STROBE: begin
                    if (strobe_cnt == '0) begin
                        state <= HOLD;
                        we_n  <= 1'b1;
                    end else begin
                        strobe_cnt <= strobe_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    we_n  <= 1'b1;
                    dq_oe <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            drop_count <= '0;
        end else if (accept && !(in_range && !keyed) && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end

    assign bus_req   = ~fifo_empty | (state != IDLE);
    assign busy      = (state != IDLE);
    assign SRAM_ADDR = addr_q;
    assign SRAM_WE_N = we_n;
    assign SRAM_DQ   = dq_oe ? dq_dat : 16'bz;
    assign SRAM_OE_N = 1'b1;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
endmodule

// File: tb/tb_sram_pixel_writer.sv
// tb_sram_pixel_writer: directed scenarios plus random traffic against a queue-based reference model.
// Latency: model predicts outputs for every clock; compare runs 1 time unit after each rising edge.
// Backpressure: the model accepts a pixel only while its queue holds fewer than FIFO_DEPTH entries.
module tb_sram_pixel_writer;
    localparam int W = 2;
    localparam int D = 4;
    localparam int H = 640;
    localparam int V = 400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld = 1'b0;
    logic        grant = 1'b0;
    logic [11:0] px = '0;
    logic [11:0] py = '0;
    logic [11:0] pc = '0;
    logic        pix_ready;
    logic        bus_req;
    logic        busy;
    logic [15:0] drop_count;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        we_n, oe_n, ce_n, ub_n, lb_n;

    // Released data bus reads back as all ones; driven data always has DQ[15:12]=0.
    for (genvar g = 0; g < 16; g++) begin : g_pu
        pullup (sram_dq[g]);
    end

    sram_pixel_writer dut (
        .CLOCK_50   (clk),
        .RESET      (rst),
        .pix_valid  (vld),
        .pix_ready  (pix_ready),
        .pix_x      (px),
        .pix_y      (py),
        .pix_color  (pc),
        .bus_grant  (grant),
        .bus_req    (bus_req),
        .busy       (busy),
        .drop_count (drop_count),
        .SRAM_ADDR  (sram_addr),
        .SRAM_DQ    (sram_dq),
        .SRAM_WE_N  (we_n),
        .SRAM_OE_N  (oe_n),
        .SRAM_CE_N  (ce_n),
        .SRAM_UB_N  (ub_n),
        .SRAM_LB_N  (lb_n)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: pending pixels as (address, data) queues, plus the timeline of the
    // write in flight measured in clocks since it started (-1 = no write in flight).
    int          qa[$];
    int          qd[$];
    int          m_t = -1;
    int          m_drops = 0;
    int          m_addr = 0;
    int          m_dq = 0;
    bit          m_drive = 0;

    function automatic bit is_keyed(input logic [11:0] c);
`ifdef COLOR_KEY_EN
        return (c == 12'h000);
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        forever begin
            bit acc;
            bit start;
            @(posedge clk);
            if (rst) begin
                qa.delete();
                qd.delete();
                m_t = -1;
                m_drops = 0;
                m_drive = 0;
                m_addr = 0;
            end else begin
                acc   = vld && (qa.size() < D);
                start = (m_t == -1 || m_t == W + 1) && (qa.size() > 0) && grant;
                if (start) begin
                    m_addr  = qa.pop_front();
                    m_dq    = qd.pop_front();
                    m_t     = 0;
                    m_drive = 1;
                end else if (m_t == W + 1) begin
                    m_t     = -1;
                    m_drive = 0;
                end else if (m_t >= 0) begin
                    m_t++;
                end
                if (acc) begin
                    if (int'(px) < H && int'(py) < V && !is_keyed(pc)) begin
                        qa.push_back(int'(py) * H + int'(px));
                        qd.push_back(int'(pc));
                    end else if (m_drops < 65535) begin
                        m_drops++;
                    end
                end
            end
        end
    end

    // Log of write strobes observed on the pins.
    int w_addr[$];
    int w_dq[$];
    int w_cyc[$];
    int low_run = 0;
    int last_low = 0;
    bit prev_we = 1'b1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            chk("pix_ready", int'(pix_ready), int'(!rst && qa.size() < D));
            chk("bus_req", int'(bus_req), int'(qa.size() > 0 || m_t != -1));
            chk("busy", int'(busy), int'(m_t != -1));
            chk("drop_count", int'(drop_count), m_drops);
            chk("we_n", int'(we_n), int'(!(m_t >= 1 && m_t <= W)));
            chk("oe_ce_ub_lb", int'({oe_n, ce_n, ub_n, lb_n}), 8);
            if (m_drive) begin
                chk("addr", int'(sram_addr), m_addr);
                chk("dq", int'(sram_dq), m_dq);
            end else begin
                chk("dq_released", int'(sram_dq), 16'hFFFF);
            end
            if (!we_n) begin
                if (prev_we) begin
                    w_addr.push_back(int'(sram_addr));
                    w_dq.push_back(int'(sram_dq));
                    w_cyc.push_back(cyc);
                end
                low_run++;
            end else if (!prev_we) begin
                last_low = low_run;
                low_run = 0;
            end
            prev_we = we_n;
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        w_addr.delete();
        w_dq.delete();
        w_cyc.delete();
    endtask

    task automatic set_pix(input int x, input int y, input int c);
        vld = 1'b1;
        px  = 12'(x);
        py  = 12'(y);
        pc  = 12'(c);
    endtask

    initial begin
        int c_acc;
        // Reset state
        wait_n(3);
        chk("reset_ready_low", int'(pix_ready), 0);
        chk("reset_we_n", int'(we_n), 1);
        chk("reset_bus_req", int'(bus_req), 0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", int'(pix_ready), 1);
        wait_n(1);
        chk("reset_drop_count", int'(drop_count), 0);
        chk("reset_addr", int'(sram_addr), 0);
        chk("reset_dq_released", int'(sram_dq), 16'hFFFF);

        // 1: single pixel with grant
        clear_log();
        grant = 1'b1;
        set_pix(5, 2, 12'h00f);
        wait_n(1);
        c_acc = cyc;
        vld = 1'b0;
        wait_n(8);
        chk("t1_writes", w_addr.size(), 1);
        if (w_addr.size() == 1) begin
            chk("t1_addr", w_addr[0], 1285);
            chk("t1_dq", w_dq[0], 16'h000f);
            chk("t1_latency", w_cyc[0] - c_acc, 2);
        end
        chk("t1_we_low_len", last_low, 2);
        chk("t1_dq_released", int'(sram_dq), 16'hFFFF);

        // 2: fill the queue without grant, then release it
        clear_log();
        grant = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_pix(i, 10 + i, 12'h100 + i);
            if (i == 4) chk("t2_ready_full", int'(pix_ready), 0);
            wait_n(1);
        end
        vld = 1'b0;
        wait_n(5);
        chk("t2_bus_req", int'(bus_req), 1);
        chk("t2_no_write", w_addr.size(), 0);
        grant = 1'b1;
        wait_n(20);
        chk("t2_writes", w_addr.size(), 4);
        if (w_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t2_addr", w_addr[i], (10 + i) * 640 + i);
                chk("t2_dq", w_dq[i], 16'h100 + i);
                if (i > 0) chk("t2_spacing", w_cyc[i] - w_cyc[i-1], 4);
            end
        end

        // 3: out-of-range pixels are dropped
        rst = 1'b1;
        wait_n(1);
        rst = 1'b0;
        clear_log();
        set_pix(640, 0, 12'h123);
        wait_n(1);
        set_pix(0, 400, 12'h123);
        wait_n(1);
        vld = 1'b0;
        wait_n(6);
        chk("t3_drop_count", int'(drop_count), 2);
        chk("t3_no_write", w_addr.size(), 0);
        chk("t3_bus_req", int'(bus_req), 0);

        // 4: grant drops during STROBE
        clear_log();
        set_pix(7, 7, 12'h321);
        wait_n(1);
        set_pix(8, 7, 12'h322);
        wait_n(1);
        vld = 1'b0;
        wait_n(1);
        chk("t4_in_strobe", int'(we_n), 0);
        grant = 1'b0;
        wait_n(6);
        chk("t4_one_write", w_addr.size(), 1);
        chk("t4_idle", int'(busy), 0);
        chk("t4_waiting", int'(bus_req), 1);
        chk("t4_we_low_len", last_low, 2);
        grant = 1'b1;
        wait_n(10);
        chk("t4_two_writes", w_addr.size(), 2);

        // 5: reset during STROBE with three pixels queued
        for (int i = 0; i < 4; i++) begin
            set_pix(20 + i, 3, 12'h0a0 + i);
            wait_n(1);
        end
        vld = 1'b0;
        chk("t5_in_strobe", int'(we_n), 0);
        chk("t5_bus_req_before", int'(bus_req), 1);
        rst = 1'b1;
        wait_n(1);
        chk("t5_we_n", int'(we_n), 1);
        chk("t5_dq_released", int'(sram_dq), 16'hFFFF);
        chk("t5_bus_req", int'(bus_req), 0);
        chk("t5_drop_count", int'(drop_count), 0);
        rst = 1'b0;
        wait_n(2);

        // 6: colour key
        clear_log();
        set_pix(1, 1, 12'h000);
        wait_n(1);
        set_pix(2, 1, 12'hff0);
        wait_n(1);
        vld = 1'b0;
        wait_n(15);
`ifdef COLOR_KEY_EN
        chk("t6_writes", w_addr.size(), 1);
        if (w_dq.size() == 1) chk("t6_dq", w_dq[0], 16'h0ff0);
        chk("t6_drop_count", int'(drop_count), 1);
`else
        chk("t6_writes", w_addr.size(), 2);
        if (w_dq.size() == 2) begin
            chk("t6_dq0", w_dq[0], 16'h0000);
            chk("t6_dq1", w_dq[1], 16'h0ff0);
        end
        chk("t6_drop_count", int'(drop_count), 0);
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            vld   = ($urandom_range(0, 1) == 1);
            px    = 12'($urandom_range(0, 700));
            py    = 12'($urandom_range(0, 450));
            pc    = ($urandom_range(0, 7) == 0) ? 12'h000 : 12'($urandom);
            grant = ($urandom_range(0, 9) < 7);
            rst   = ($urandom_range(0, 399) == 0);
            wait_n(1);
        end
        vld = 1'b0;
        rst = 1'b0;
        grant = 1'b1;
        wait_n(30);
        chk("drain_idle", int'(bus_req), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
